seq_det_ctrl: RTL and testbench

Programmable serial-pattern detection controller for the bit-stream datapath. It latches a pattern, length, overlap mode, match target and observation window at `start`. It then runs a detection session over qualified `din` bits and counts matches. The session ends on reaching the target, on window expiry, or on `abort`. It replaces fixed single-pattern detectors where software must arm, bound and read back a detection session.

---
 rtl/seq_det_ctrl.sv | 140 ++++++++++++++
 tb/tb_seq_det_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_ctrl.sv
// Programmable serial-pattern detection controller: arms a session on start,
// counts pattern matches on qualified bits, and stops on target, window expiry or abort.
module seq_det_ctrl #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    parameter int WIN_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PAT_W-1:0]       cfg_pattern,
    input  logic [$clog2(PAT_W):0] cfg_len,
    input  logic                   cfg_overlap,
    input  logic [CNT_W-1:0]       cfg_target,
    input  logic [WIN_W-1:0]       cfg_window,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   din,
    input  logic                   din_valid,
    output logic                   busy,
    output logic                   match,
    output logic [CNT_W-1:0]       match_count,
    output logic                   done,
    output logic                   timeout
);

    localparam int LEN_W = $clog2(PAT_W) + 1;
    localparam logic [LEN_W-1:0] FULL = LEN_W'(PAT_W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [PAT_W-1:0] r_pat;
    logic [LEN_W-1:0] r_len;
    logic             r_overlap;
    logic [CNT_W-1:0] r_target;
    logic [WIN_W-1:0] r_window;
    logic [PAT_W-1:0] r_hist;
    logic [LEN_W-1:0] r_fill;
    logic [WIN_W-1:0] r_wcnt;
    logic [CNT_W-1:0] r_count;
    logic             r_match;
    logic             r_done;
    logic             r_timeout;

    logic [LEN_W-1:0] w_len_clamp;
    logic             w_accept;
    logic [PAT_W-1:0] w_hist_nxt;
    logic [LEN_W-1:0] w_fill_inc;
    logic [PAT_W-1:0] w_mask;
    logic             w_hit;
    logic [CNT_W-1:0] w_count_nxt;
    logic [WIN_W-1:0] w_wcnt_inc;
    logic             w_tgt;
    logic             w_win;

    assign w_len_clamp = (cfg_len == '0 || cfg_len > FULL) ? FULL : cfg_len;
    assign w_accept    = (r_state == S_RUN) && din_valid;
    assign w_hist_nxt  = {r_hist[PAT_W-2:0], din};
    assign w_fill_inc  = (r_fill < FULL) ? r_fill + 1'b1 : r_fill;
    assign w_wcnt_inc  = r_wcnt + 1'b1;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
    end

    // Match is judged on the history as it will be after this bit shifts in
    assign w_hit = w_accept && (w_fill_inc >= r_len)
                   && (((w_hist_nxt ^ r_pat) & w_mask) == '0);

    assign w_count_nxt = (w_hit && r_count != '1) ? r_count + 1'b1 : r_count;
    assign w_tgt = w_hit && (r_target != '0) && (w_count_nxt == r_target);
    assign w_win = w_accept && (r_window != '0) && (w_wcnt_inc == r_window) && !w_tgt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pat     <= '0;
            r_len     <= '0;
            r_overlap <= 1'b0;
            r_target  <= '0;
            r_window  <= '0;
            r_hist    <= '0;
            r_fill    <= '0;
            r_wcnt    <= '0;
            r_count   <= '0;
            r_match   <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else if (abort) begin
            r_state   <= S_IDLE;
            r_match   <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else if (start && r_state != S_RUN) begin
            r_state   <= S_RUN;
            r_pat     <= cfg_pattern;
            r_len     <= w_len_clamp;
            r_overlap <= cfg_overlap;
            r_target  <= cfg_target;
            r_window  <= cfg_window;
            r_hist    <= '0;
            r_fill    <= '0;
            r_wcnt    <= '0;
            r_count   <= '0;
            r_match   <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_match <= w_hit;
            if (din_valid) begin
                r_hist  <= w_hist_nxt;
                // Non-overlapping mode forgets history so the next match needs len fresh bits
                r_fill  <= (w_hit && !r_overlap) ? '0 : w_fill_inc;
                r_wcnt  <= w_wcnt_inc;
                r_count <= w_count_nxt;
                if (w_tgt) begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end else if (w_win) begin
                    r_state   <= S_DONE;
                    r_timeout <= 1'b1;
                end
            end
        end else begin
            r_match <= 1'b0;
        end
    end

    assign busy        = (r_state == S_RUN);
    assign match       = r_match;
    assign match_count = r_count;
    assign done        = r_done;
    assign timeout     = r_timeout;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: directed sessions from the feature list plus random
// traffic compared cycle by cycle against a queue-based reference model.
module tb_seq_det_ctrl;

    localparam int PAT_W = 8;
    localparam int CNT_W = 8;
    localparam int WIN_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [PAT_W-1:0] cfg_pattern;
    logic [3:0]       cfg_len;
    logic             cfg_overlap;
    logic [CNT_W-1:0] cfg_target;
    logic [WIN_W-1:0] cfg_window;
    logic             start, abort, din, din_valid;
    logic             busy, match, done, timeout;
    logic [CNT_W-1:0] match_count;

    int n_chk  = 0;
    int n_fail = 0;

    seq_det_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
        .clk(clk), .rst(rst),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cfg_target(cfg_target), .cfg_window(cfg_window),
        .start(start), .abort(abort), .din(din), .din_valid(din_valid),
        .busy(busy), .match(match), .match_count(match_count),
        .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Reference model: session state plus a queue of received bits
    int m_state;   // 0 idle, 1 run, 2 done
    int m_pat, m_len, m_ov, m_tgt, m_win, m_wc, m_cnt;
    bit m_match, m_done, m_to;
    bit m_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_state = 0; m_pat = 0; m_len = 0; m_ov = 0; m_tgt = 0; m_win = 0;
        m_wc = 0; m_cnt = 0; m_match = 0; m_done = 0; m_to = 0;
        m_q.delete();
    endtask

    task automatic m_update();
        bit hit, reached;
        m_match = 0;
        if (abort) begin
            m_state = 0; m_done = 0; m_to = 0;
        end else if (start && m_state != 1) begin
            m_state = 1;
            m_pat = int'(cfg_pattern);
            m_len = (cfg_len == 0 || cfg_len > PAT_W) ? PAT_W : int'(cfg_len);
            m_ov  = int'(cfg_overlap);
            m_tgt = int'(cfg_target);
            m_win = int'(cfg_window);
            m_q.delete();
            m_wc = 0; m_cnt = 0; m_done = 0; m_to = 0;
        end else if (m_state == 1 && din_valid) begin
            m_q.push_back(din);
            if (m_q.size() > PAT_W) void'(m_q.pop_front());
            m_wc++;
            hit = (m_q.size() >= m_len);
            for (int j = 0; j < m_len && hit; j++)
                if (m_q[m_q.size() - 1 - j] != m_pat[j]) hit = 0;
            if (hit) begin
                m_match = 1;
                if (m_cnt < 255) m_cnt++;
                if (m_ov == 0) m_q.delete();
            end
            reached = hit && m_tgt != 0 && m_cnt == m_tgt;
            if (reached) begin
                m_state = 2; m_done = 1;
            end else if (m_win != 0 && (m_wc % 65536) == m_win) begin
                m_state = 2; m_to = 1;
            end
        end
    endtask

    task automatic step(input logic s, input logic a, input logic d, input logic dv);
        start = s; abort = a; din = d; din_valid = dv;
        @(posedge clk);
        m_update();
        #1;
        chk("busy", busy, m_state == 1);
        chk("match", match, m_match);
        chk("match_count", match_count, m_cnt);
        chk("done", done, m_done);
        chk("timeout", timeout, m_to);
    endtask

    task automatic set_cfg(input int pat, input int len, input int ov, input int tgt, input int win);
        cfg_pattern = PAT_W'(pat); cfg_len = 4'(len); cfg_overlap = ov[0];
        cfg_target = CNT_W'(tgt); cfg_window = WIN_W'(win);
    endtask

    // Stream 1,0,1,1,0,1,0,1,0 with optional idle gaps between bits
    task automatic run_stream(input bit gaps);
        logic [8:0] s;
        s = 9'b101101010;
        step(1, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            step(0, 0, s[8-i], 1);
            if (gaps) step(0, 0, ~s[8-i], 0);
        end
        step(0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        set_cfg(0, 0, 0, 0, 0);
        start = 0; abort = 0; din = 0; din_valid = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_match", match, 0);
        chk("rst_count", match_count, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        #2 rst = 1'b0;

        // Overlapping: matches after bits 7 and 9, window expires
        set_cfg('b1010, 4, 1, 0, 9);
        run_stream(0);
        chk("ovl_count", match_count, 2);
        chk("ovl_timeout", timeout, 1);
        chk("ovl_done", done, 0);

        // Same with din_valid gaps: gaps must not shift or advance the window
        run_stream(1);
        chk("gap_count", match_count, 2);
        chk("gap_timeout", timeout, 1);

        // Non-overlapping
        set_cfg('b1010, 4, 0, 0, 9);
        run_stream(0);
        chk("novl_count", match_count, 1);
        chk("novl_timeout", timeout, 1);

        // Target stop after bit 4
        set_cfg('b1011, 4, 1, 1, 0);
        run_stream(0);
        chk("tgt_count", match_count, 1);
        chk("tgt_done", done, 1);
        chk("tgt_busy", busy, 0);

        // Target and window on the same bit
        set_cfg('b1010, 4, 1, 2, 9);
        run_stream(0);
        chk("coin_done", done, 1);
        chk("coin_timeout", timeout, 0);
        chk("coin_count", match_count, 2);

        // Mid-run start and pattern change are ignored; abort beats start
        set_cfg('b1010, 4, 1, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 1, 1);
        step(0, 0, 0, 1);
        step(0, 0, 1, 1);
        set_cfg('b0000, 2, 0, 1, 1);
        step(1, 0, 0, 1);
        chk("midstart_match", match, 1);
        chk("midstart_count", match_count, 1);
        step(1, 1, 0, 1);
        chk("abort_busy", busy, 0);
        chk("abort_count", match_count, 1);
        step(0, 0, 1, 1);

        // Asynchronous reset between edges during a run
        set_cfg('b10, 2, 1, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 1, 1);
        step(0, 0, 0, 1);
        step(0, 0, 1, 1);
        chk("pre_rst_count", match_count, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_match", match, 0);
        chk("arst_count", match_count, 0);
        chk("arst_done", done, 0);
        chk("arst_timeout", timeout, 0);
        #1 rst = 1'b0;
        m_reset();
        step(0, 0, 1, 1);
        step(0, 0, 0, 1);

        // Random traffic with config churning every cycle
        for (int n = 0; n < 3000; n++) begin
            set_cfg($urandom, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 3),
                    $urandom_range(0, 1), $urandom_range(0, 4),
                    ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(3, 40));
            step($urandom_range(0, 15) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 1), $urandom_range(0, 9) < 7);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
